// File: rtl/dmem_request_ctrl.sv
// rtl/dmem_request_ctrl.sv - data-memory request controller
// Accepts one load/store at a time, validates it, strobes memory and returns a one-cycle response.
module dmem_request_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  access_err,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, WRITE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [3:0]  mask_dec;
  logic        illegal;
  logic        misaligned;
  logic [1:0]  err_code;

  assign req_ready = (state == IDLE);
  assign stall     = (state != IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    mask_dec = 4'b0000;
    illegal  = 1'b0;
    if (req_write) begin
      case (req_funct3)
        3'b000:  mask_dec = 4'b0001;
        3'b001:  mask_dec = 4'b0011;
        3'b010:  mask_dec = 4'b0111;
        default: illegal  = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000:  mask_dec = 4'b1001;
        3'b001:  mask_dec = 4'b1011;
        3'b010:  mask_dec = 4'b0111;
        3'b100:  mask_dec = 4'b0001;
        3'b101:  mask_dec = 4'b0011;
        default: illegal  = 1'b1;
      endcase
    end
  end

  // funct3[1:0] encodes access size for every legal code: 00 byte, 01 half, 10 word
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign err_code   = illegal ? 2'b10 : (misaligned ? 2'b01 : 2'b00);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && (err_code == 2'b00)) begin
          state_nxt = req_write ? WRITE : READ;
        end
      end
      READ:    state_nxt = CAPT;
      CAPT:    state_nxt = IDLE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr       <= 32'd0;
      mem_write_data <= 32'd0;
      mem_sign_mask  <= 4'd0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      resp_valid     <= 1'b0;
      access_err     <= 2'b00;
      resp_rdata     <= 32'd0;
    end else begin
      mem_memread  <= accept && (err_code == 2'b00) && !req_write;
      mem_memwrite <= accept && (err_code == 2'b00) && req_write;
      resp_valid   <= (accept && (err_code != 2'b00)) || (state == CAPT) || (state == WRITE);
      access_err   <= accept ? err_code : 2'b00;
      if (accept) begin
        mem_addr       <= req_addr;
        mem_write_data <= req_wdata;
        mem_sign_mask  <= mask_dec;
      end
      if (state == CAPT) begin
        resp_rdata <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_request_ctrl.sv
// tb/tb_dmem_request_ctrl.sv - self-checking bench for dmem_request_ctrl
// Transaction-level model predicts per-cycle outputs; literal checks pin key scenarios.
module tb_dmem_request_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  access_err;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = 32'd0;

  dmem_request_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .access_err(access_err), .stall(stall), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit fixed_en = 1'b0;
  logic [31:0] fixed_val = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    mem_read_data = fixed_en ? fixed_val : $urandom;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void decode(input logic w, input logic [2:0] f, input logic [31:0] a,
                                 output logic [3:0] m, output logic [1:0] e);
    int size;
    bit legal;
    m = 4'd0; size = 1; legal = 1'b1;
    if (!w) begin
      case (f)
        3'd0: begin m = 4'b1001; size = 1; end
        3'd1: begin m = 4'b1011; size = 2; end
        3'd2: begin m = 4'b0111; size = 4; end
        3'd4: begin m = 4'b0001; size = 1; end
        3'd5: begin m = 4'b0011; size = 2; end
        default: legal = 1'b0;
      endcase
    end else begin
      case (f)
        3'd0: begin m = 4'b0001; size = 1; end
        3'd1: begin m = 4'b0011; size = 2; end
        3'd2: begin m = 4'b0111; size = 4; end
        default: legal = 1'b0;
      endcase
    end
    if (!legal) e = 2'b10;
    else if ((a % size) != 0) e = 2'b01;
    else e = 2'b00;
  endfunction

  // Model: one transaction in flight, scheduled by absolute cycle numbers
  int          free_at = 0, rd_cyc = -1, wr_cyc = -1, resp_cyc = -1, cap_cyc = -1;
  bit          pend_load = 1'b0;
  logic [1:0]  pend_err = 2'b00;
  logic [31:0] cap_val = 32'd0, exp_rdata = 32'd0, exp_addr = 32'd0, exp_wdata = 32'd0;
  logic [3:0]  exp_mask = 4'd0;

  always @(negedge clk) begin
    logic [3:0] m;
    logic [1:0] e;
    bit exp_ready, exp_rv;
    if (!rst_n) begin
      free_at = 0; rd_cyc = -1; wr_cyc = -1; resp_cyc = -1; cap_cyc = -1;
      pend_load = 1'b0; exp_rdata = 0; exp_addr = 0; exp_wdata = 0; exp_mask = 0;
      check("rst_ready", req_ready, 1);
      check("rst_stall", stall, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_err", access_err, 0);
      check("rst_strobes", {mem_memread, mem_memwrite}, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_write_data, 0);
      check("rst_mask", mem_sign_mask, 0);
      check("rst_rdata", resp_rdata, 0);
    end else begin
      exp_ready = (cyc >= free_at);
      exp_rv = (cyc == resp_cyc);
      if (cyc == cap_cyc) cap_val = mem_read_data;
      if (exp_rv && pend_load) exp_rdata = cap_val;
      check("ready", req_ready, exp_ready);
      check("stall", stall, !exp_ready);
      check("memread", mem_memread, cyc == rd_cyc);
      check("memwrite", mem_memwrite, cyc == wr_cyc);
      check("resp_valid", resp_valid, exp_rv);
      check("access_err", access_err, exp_rv ? pend_err : 2'b00);
      check("resp_rdata", resp_rdata, exp_rdata);
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wdata", mem_write_data, exp_wdata);
      check("mem_mask", mem_sign_mask, exp_mask);
      if (exp_ready && req_valid) begin
        decode(req_write, req_funct3, req_addr, m, e);
        exp_addr = req_addr; exp_wdata = req_wdata; exp_mask = m;
        pend_err = e;
        pend_load = (e == 2'b00) && !req_write;
        rd_cyc = -1; wr_cyc = -1; cap_cyc = -1;
        if (e != 2'b00) begin
          resp_cyc = cyc + 1; free_at = cyc + 1;
        end else if (req_write) begin
          wr_cyc = cyc + 1; resp_cyc = cyc + 2; free_at = cyc + 2;
        end else begin
          rd_cyc = cyc + 1; cap_cyc = cyc + 2; resp_cyc = cyc + 3; free_at = cyc + 3;
        end
      end
    end
  end

  // Returns #1 after the accepting edge, i.e. early in cycle C+1
  task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req_write = w; req_funct3 = f; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      req_valid = 1'b0;
      check("accept_timeout", 0, 1);
    end
  endtask

  typedef struct { logic w; logic [2:0] f; logic [31:0] a; logic [31:0] d; } vec_t;
  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 3'd2, 32'h0000_2000, 32'h0};
    vecs[1] = '{1'b0, 3'd1, 32'h0000_2002, 32'h0};
    vecs[2] = '{1'b0, 3'd5, 32'h0000_2006, 32'h0};
    vecs[3] = '{1'b0, 3'd4, 32'h0000_2007, 32'h0};
    vecs[4] = '{1'b1, 3'd1, 32'h0000_3002, 32'h0000_BEEF};
    vecs[5] = '{1'b1, 3'd0, 32'h0000_3003, 32'h0000_00A5};
    vecs[6] = '{1'b1, 3'd4, 32'h0000_3000, 32'h1234_5678};
    vecs[7] = '{1'b0, 3'd2, 32'h0000_2002, 32'h0};
    vecs[8] = '{1'b0, 3'd6, 32'h0000_2001, 32'h0};
    vecs[9] = '{1'b1, 3'd2, 32'h0000_3001, 32'hCAFE_F00D};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // LB at 0x1003 returning 0xFFFFFF80
    fixed_en = 1'b1; fixed_val = 32'hFFFF_FF80;
    do_req(1'b0, 3'd0, 32'h0000_1003, 32'h0);
    @(negedge clk);
    check("lb_memread_c1", mem_memread, 1);
    check("lb_mask_c1", mem_sign_mask, 4'b1001);
    check("lb_addr_c1", mem_addr, 32'h0000_1003);
    repeat (2) @(negedge clk);
    check("lb_resp_c3", resp_valid, 1);
    check("lb_rdata_c3", resp_rdata, 32'hFFFF_FF80);
    check("lb_err_c3", access_err, 2'b00);
    fixed_en = 1'b0;

    // SW 0xDEADBEEF at 0x1004
    do_req(1'b1, 3'd2, 32'h0000_1004, 32'hDEAD_BEEF);
    @(negedge clk);
    check("sw_memwrite_c1", mem_memwrite, 1);
    check("sw_addr_c1", mem_addr, 32'h0000_1004);
    check("sw_mask_c1", mem_sign_mask, 4'b0111);
    check("sw_data_c1", mem_write_data, 32'hDEAD_BEEF);
    @(negedge clk);
    check("sw_resp_c2", resp_valid, 1);
    check("sw_rdata_hold", resp_rdata, 32'hFFFF_FF80);

    // Misaligned LH and illegal funct3
    do_req(1'b0, 3'd1, 32'h0000_1001, 32'h0);
    @(negedge clk);
    check("lh_mis_resp", resp_valid, 1);
    check("lh_mis_err", access_err, 2'b01);
    check("lh_mis_strobes", {mem_memread, mem_memwrite}, 2'b00);
    do_req(1'b0, 3'd3, 32'h0000_1000, 32'h0);
    @(negedge clk);
    check("lw_ill_err", access_err, 2'b10);

    // Back-to-back SB then LBU with req_valid held
    begin
      logic [5:0] rs;
      @(posedge clk); #1;
      req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h0000_4001; req_wdata = 32'h0000_0077;
      req_valid = 1'b1;
      @(negedge clk); rs[5] = req_ready;
      @(posedge clk); #1;
      req_write = 1'b0; req_funct3 = 3'd4; req_addr = 32'h0000_4002;
      @(negedge clk); rs[4] = req_ready;
      @(posedge clk); #1;
      @(negedge clk); rs[3] = req_ready;
      check("b2b_resp_at_accept", resp_valid, 1);
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk); rs[2] = req_ready;
      check("b2b_lbu_memread", mem_memread, 1);
      @(negedge clk); rs[1] = req_ready;
      @(negedge clk); rs[0] = req_ready;
      check("b2b_ready_seq", rs, 6'b101001);
    end

    // Table of directed accesses, with input churn while busy on one load
    foreach (vecs[i]) do_req(vecs[i].w, vecs[i].f, vecs[i].a, vecs[i].d);
    do_req(1'b0, 3'd2, 32'h0000_5000, 32'h0);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h1;
    @(posedge clk); #1 req_addr = 32'h0000_0003;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Reset during READ
    do_req(1'b0, 3'd2, 32'h0000_6000, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_memread", mem_memread, 0);
    check("rst_mid_stall", stall, 0);
    check("rst_mid_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_after_no_resp", resp_valid, 0);
    fixed_en = 1'b1; fixed_val = 32'h0000_0042;
    do_req(1'b0, 3'd4, 32'h0000_6001, 32'h0);
    repeat (3) @(negedge clk);
    check("post_rst_resp", resp_valid, 1);
    check("post_rst_rdata", resp_rdata, 32'h0000_0042);
    fixed_en = 1'b0;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_request_ctrl.md
DMEM_REQUEST_CTRL -- requirements
Module: dmem_request_ctrl

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset; clk is the only clock and rst_n the only reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  pipeline load/store request; held stable until accepted.
REQ-005 req_ready  output  1  request accepted on a clk edge when req_valid&&req_ready.
REQ-006 req_write  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RV32I funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, unshifted, in low lanes.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  formatted load result, valid with resp_valid on loads.
REQ-012 access_err  output  2  with resp_valid: 00 ok, 01 misaligned, 10 illegal funct3.
REQ-013 stall  output  1  pipeline hold while a request is in flight.
REQ-014 mem_addr  output  32  to data memory addr.
REQ-015 mem_write_data  output  32  to data memory write_data.
REQ-016 mem_memread  output  1  read strobe.
REQ-017 mem_memwrite  output  1  write strobe.
REQ-018 mem_sign_mask  output  4  [3]=sign-extend, [2:0]=001 byte / 011 half / 111 word.
REQ-019 mem_read_data  input  32  memory formatted read data, valid the cycle after mem_memread.

Function
REQ-020 SHALL implement FSM states IDLE, READ, CAPT, WRITE; req_ready=1 only in IDLE; stall=1 in every state except IDLE.
REQ-021 In IDLE on accept, SHALL register req_addr->mem_addr, req_wdata->mem_write_data, and the decoded mask->mem_sign_mask; these are held until the next accept.
REQ-022 Mask decode: LB 1001, LH 1011, LW 0111, LBU 0001, LHU 0011, SB 0001, SH 0011, SW 0111.
REQ-023 Legal funct3: loads {000,001,010,100,101}, stores {000,001,010}; any other value SHALL produce error 10, with no memory strobe.
REQ-024 Misaligned: halfword with addr[0]=1 or word with addr[1:0]!=00 SHALL produce error 01, with no memory strobe; illegal funct3 has priority over misalignment.
REQ-025 Error path: accept in cycle C -> cycle C+1 is IDLE with resp_valid=1 and access_err set; resp_rdata is unchanged.
REQ-026 Load path: accept in C -> READ in C+1 with mem_memread=1 -> CAPT in C+2 (mem_read_data sampled at the end of C+2) -> IDLE in C+3 with resp_valid=1, resp_rdata=sampled value, access_err=00.
REQ-027 Store path: accept in C -> WRITE in C+1 with mem_memwrite=1 -> IDLE in C+2 with resp_valid=1, access_err=00, resp_rdata unchanged.
REQ-028 mem_memread and mem_memwrite SHALL be registered outputs, never both 1, each high for exactly one cycle per access.
REQ-029 resp_valid SHALL be high for exactly one cycle; a new request MAY be accepted in the same cycle (back-to-back).
REQ-030 req_valid or input changes outside IDLE SHALL be ignored.
REQ-031 access_err SHALL read 00 whenever resp_valid=0.

Reset
REQ-032 While rst_n=0, asynchronously: state=IDLE, req_ready=1, stall=0, resp_valid=0, access_err=00, mem_memread=0, mem_memwrite=0, mem_addr=0, mem_write_data=0, mem_sign_mask=0, resp_rdata=0.
REQ-033 Reset asserted mid-access SHALL abort the access with no resp_valid; the first edge after release SHALL see IDLE.

Verification
REQ-034 LB at addr 0x1003, memory returns 0xFFFFFF80 -> memread pulse in C+1 with mask 1001, resp_valid in C+3 with resp_rdata=0xFFFFFF80 and err 00.
REQ-035 SW 0xDEADBEEF at 0x1004 -> memwrite pulse in C+1 with mem_addr=0x1004, mask 0111, data 0xDEADBEEF; resp_valid in C+2.
REQ-036 LH at 0x1001 -> no strobe, resp_valid in C+1 with access_err=01; LW with funct3=011 -> access_err=10.
REQ-037 SB then LBU issued back-to-back with req_valid held -> second accept in the cycle of the first resp_valid; ready/stall sequence 1,0,1,0,0,1.
REQ-038 rst_n pulled low during READ -> strobes and stall drop immediately; no resp_valid; next request completes normally.
